serial_word_receiver: RTL and testbench

- Receive end of the serial link fed by the team's PISO shift register.
- Accepts an MSB-first bit stream, one bit per qualified clock, and reassembles WIDTH-bit words.
- Presents each word on a valid/ready parallel output through a one-entry holding register.
- Detects overrun and framing errors and reports them as sticky flags.

---
 rtl/serial_link_pkg.sv | 12 +
 rtl/rx_holding_reg.sv | 54 +++++
 rtl/serial_word_receiver.sv | 113 +++++++++++
 tb/tb_serial_word_receiver.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_link_pkg.sv
// Definitions shared by both ends of the serial link: word width default
// and the receiver FSM state type.
package serial_link_pkg;

  localparam int DEFAULT_WORD_WIDTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_t;

endpackage

// File: rtl/rx_holding_reg.sv
// One-entry output buffer for received words; flags a drop when a new word
// arrives while the held word is neither consumed nor consumable this edge.
module rx_holding_reg
  import serial_link_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WORD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             overrun_set
);

  // Handshake: a word transfers on every rising edge where valid_out=1 and
  // out_ready=1; data_out is held constant while valid_out=1 && out_ready=0.
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             drop;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    drop    = 1'b0;
    if (load_valid) begin
      if (!valid_q || out_ready) begin
        data_d  = load_data;
        valid_d = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign overrun_set = drop;

endmodule

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel receiver: reassembles MSB-first frames into WIDTH-bit
// words and hands them to a one-entry valid/ready holding register.
module serial_word_receiver
  import serial_link_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WORD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_valid,
  input  logic             frame_start,
  input  logic             serial_in,
  input  logic             out_ready,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  rx_state_t        state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  // Only the first WIDTH-1 bits need storage: the last bit goes straight
  // into the completed word.
  logic [WIDTH-2:0] shift_q, shift_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;
  logic [WIDTH-1:0] shifted;
  logic             word_done;
  logic             frame_abort;
  logic             overrun_set;

  assign shifted = {shift_q, serial_in};

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    shift_d     = shift_q;
    word_done   = 1'b0;
    frame_abort = 1'b0;
    if (bit_valid) begin
      case (state_q)
        IDLE: begin
          if (frame_start) begin
            shift_d = shifted[WIDTH-2:0];
            count_d = CW'(1);
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          shift_d = shifted[WIDTH-2:0];
          if (frame_start) begin
            frame_abort = 1'b1;
            count_d     = CW'(1);
          end else if (count_q == LAST_IDX) begin
            word_done = 1'b1;
            count_d   = '0;
            state_d   = IDLE;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == SHIFT);

    // A set event on the same edge as clear_flags must win.
    overrun_d   = clear_flags ? 1'b0 : overrun_q;
    frame_err_d = clear_flags ? 1'b0 : frame_err_q;
    if (overrun_set) overrun_d = 1'b1;
    if (frame_abort) frame_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      shift_q     <= '0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      shift_q     <= shift_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  rx_holding_reg #(.WIDTH(WIDTH)) u_hold (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (word_done),
    .load_data   (shifted),
    .out_ready   (out_ready),
    .data_out    (parallel_out),
    .valid_out   (out_valid),
    .overrun_set (overrun_set)
  );

  assign busy      = busy_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver (WIDTH=4): behavioural frame model
// checked every cycle, literal checks per scenario, and a transfer scoreboard.
module tb_serial_word_receiver;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         bit_valid = 1'b0;
  logic         frame_start = 1'b0;
  logic         serial_in = 1'b0;
  logic         out_ready = 1'b1;
  logic         clear_flags = 1'b0;
  logic [W-1:0] parallel_out;
  logic         out_valid;
  logic         busy;
  logic         overrun;
  logic         frame_err;

  int n_cmp = 0;
  int n_fail = 0;
  bit run_chk = 1'b0;

  logic [W-1:0] exp_q[$];

  serial_word_receiver #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .bit_valid    (bit_valid),
    .frame_start  (frame_start),
    .serial_in    (serial_in),
    .out_ready    (out_ready),
    .clear_flags  (clear_flags),
    .parallel_out (parallel_out),
    .out_valid    (out_valid),
    .busy         (busy),
    .overrun      (overrun),
    .frame_err    (frame_err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Frame-level view: collect bits of the current frame as a number, and
  // when WIDTH of them have arrived offer the number to a one-slot buffer.
  int           m_acc = 0;
  int           m_n = 0;
  bit           m_in_frame = 1'b0;
  logic [W-1:0] m_data = '0;
  bit           m_valid = 1'b0;
  bit           m_ov = 1'b0;
  bit           m_fe = 1'b0;

  task automatic model_step();
    bit done = 1'b0;
    bit set_ov = 1'b0;
    bit set_fe = 1'b0;
    if (bit_valid) begin
      if (frame_start) begin
        if (m_in_frame) set_fe = 1'b1;
        m_acc = int'(serial_in);
        m_n = 1;
        m_in_frame = 1'b1;
      end else if (m_in_frame) begin
        m_acc = m_acc * 2 + int'(serial_in);
        m_n = m_n + 1;
        if (m_n == W) begin
          done = 1'b1;
          m_in_frame = 1'b0;
        end
      end
    end
    if (done) begin
      if (!m_valid || out_ready) begin
        m_data = m_acc[W-1:0];
        m_valid = 1'b1;
      end else begin
        set_ov = 1'b1;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    if (clear_flags) begin
      m_ov = 1'b0;
      m_fe = 1'b0;
    end
    if (set_ov) m_ov = 1'b1;
    if (set_fe) m_fe = 1'b1;
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_acc = 0; m_n = 0; m_in_frame = 1'b0;
      m_data = '0; m_valid = 1'b0; m_ov = 1'b0; m_fe = 1'b0;
    end else begin
      model_step();
    end
  end

  // ---------------- per-cycle compare + transfer scoreboard ----------------
  initial forever begin
    @(negedge clk);
    if (run_chk && !reset) begin
      chk("cyc_out_valid", out_valid, m_valid);
      if (m_valid) chk("cyc_parallel_out", parallel_out, m_data);
      chk("cyc_busy", busy, m_in_frame);
      chk("cyc_overrun", overrun, m_ov);
      chk("cyc_frame_err", frame_err, m_fe);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_word", parallel_out, 32'hFFFF_FFFF);
        end else begin
          chk("sb_word", parallel_out, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic fs, input logic b);
    bit_valid = 1'b1;
    frame_start = fs;
    serial_in = b;
    @(posedge clk);
    #2;
    bit_valid = 1'b0;
    frame_start = 1'b0;
    serial_in = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] w);
    logic [W-1:0] v;
    v = w;
    for (int i = W - 1; i >= 0; i--) send_bit(i == W - 1, v[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst_parallel_out", parallel_out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_frame_err", frame_err, 0);
    reset = 1'b0;
    run_chk = 1'b1;

    // Basic frame 1011
    exp_q.push_back(4'b1011);
    send_frame(4'b1011);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_parallel_out", parallel_out, 4'b1011);
    chk("t1_busy", busy, 0);
    idle(2);

    // Same frame with a 3-cycle stall between bits 2 and 3
    exp_q.push_back(4'b1011);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("t2_busy_gap", busy, 1);
      idle(1);
    end
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    chk("t2_parallel_out", parallel_out, 4'b1011);
    chk("t2_out_valid", out_valid, 1);
    chk("t2_overrun", overrun, 0);
    chk("t2_frame_err", frame_err, 0);
    idle(2);

    // Overrun: 0110 held, 1001 dropped
    out_ready = 1'b0;
    exp_q.push_back(4'b0110);
    send_frame(4'b0110);
    chk("t3_first_valid", out_valid, 1);
    send_frame(4'b1001);
    chk("t3_held_word", parallel_out, 4'b0110);
    chk("t3_overrun", overrun, 1);
    out_ready = 1'b1;
    idle(1);
    chk("t3_drained", out_valid, 0);
    chk("t3_overrun_sticky", overrun, 1);
    clear_flags = 1'b1;
    idle(1);
    clear_flags = 1'b0;
    chk("t3_overrun_cleared", overrun, 0);

    // Back-to-back: consume and load on the same edge
    out_ready = 1'b0;
    exp_q.push_back(4'b1100);
    exp_q.push_back(4'b0011);
    send_frame(4'b1100);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    chk("t4_old_word", parallel_out, 4'b1100);
    out_ready = 1'b1;
    send_bit(1'b0, 1'b1);
    chk("t4_out_valid", out_valid, 1);
    chk("t4_parallel_out", parallel_out, 4'b0011);
    chk("t4_overrun", overrun, 0);
    idle(1);

    // Frame abort, with clear_flags on the abort edge (set wins)
    exp_q.push_back(4'b0101);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    clear_flags = 1'b1;
    send_bit(1'b1, 1'b0);
    clear_flags = 1'b0;
    chk("t5_frame_err_set_wins", frame_err, 1);
    chk("t5_busy", busy, 1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    chk("t5_frame_err", frame_err, 1);
    chk("t5_parallel_out", parallel_out, 4'b0101);
    idle(1);
    clear_flags = 1'b1;
    idle(1);
    clear_flags = 1'b0;
    chk("t5_frame_err_cleared", frame_err, 0);

    // Async reset mid-frame while a word is held; that word is discarded
    out_ready = 1'b0;
    send_frame(4'b0111);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    chk("t6_pre_valid", out_valid, 1);
    chk("t6_pre_busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_parallel_out", parallel_out, 0);
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_overrun", overrun, 0);
    chk("t6_rst_frame_err", frame_err, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    out_ready = 1'b1;
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    chk("t6_idle_ignores", busy, 0);
    exp_q.push_back(4'b1110);
    send_frame(4'b1110);
    chk("t6_parallel_out", parallel_out, 4'b1110);
    chk("t6_out_valid", out_valid, 1);
    chk("t6_frame_err", frame_err, 0);
    idle(2);

    chk("sb_all_words_delivered", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
